// File: rtl/sha256_iter_core.sv
`default_nettype none
// ============================================================================
// Module      : sha256_iter_core
// Description : Iterative SHA-256 / SHA-224 compression core. It accepts one
//               padded 512-bit block at a time, runs ROUNDS_PER_CYCLE rounds
//               per clock, and chains the hash state across the blocks of a
//               message.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_iter_core #(
  parameter int ROUNDS_PER_CYCLE = 1,   // 1, 2, 4 or 8
  parameter bit SUPPORT_224      = 1'b1
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         block_valid_i,
  output logic         block_ready_o,
  input  logic [511:0] block_in_i,
  input  logic         first_i,
  input  logic         last_i,
  input  logic         mode_224_i,
  output logic         busy_o,
  output logic         digest_valid_o,
  output logic [255:0] digest_o
);

  // Element 0 is working register a (or H0); element 0 of the window is W[t].
  typedef logic [7:0][31:0]  hash_t;
  typedef logic [15:0][31:0] win_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [5:0] RND_STEP = 6'(ROUNDS_PER_CYCLE);
  localparam logic [5:0] RND_LAST = 6'(64 - ROUNDS_PER_CYCLE);

  localparam hash_t IV_256 = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                              32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  localparam hash_t IV_224 = {32'hbefa4fa4, 32'h64f98fa7, 32'h68581511, 32'hffc00b31,
                              32'hf70e5939, 32'h3070dd17, 32'h367cd507, 32'hc1059ed8};

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic logic [31:0] sml_s0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sml_s1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  // H0 goes to the top word; SHA-224 drops H7.
  function automatic logic [255:0] fmt_digest(input hash_t h, input logic m224);
    logic [255:0] d;
    d = {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
    if (m224) d[31:0] = 32'h0;
    return d;
  endfunction

  state_e         state_q;
  hash_t          h_q, work_q, work_d, w_h_sum, w_h_init;
  win_t           w_q, win_d, w_blk_win;
  logic [5:0]     rnd_q;
  logic           last_q, mode_q, chain_q;
  logic           ready_q, busy_q, dv_q;
  logic [255:0]   digest_q;
  logic           w_accept, w_mode_sel, w_use_iv;

  assign block_ready_o  = ready_q;
  assign busy_o         = busy_q;
  assign digest_valid_o = dv_q;
  assign digest_o       = digest_q;

  // Block acceptance: pick the starting hash (IV or chained) and unpack the words.
  always_comb begin
    w_accept   = block_valid_i && ready_q && (state_q == IDLE);
    w_mode_sel = first_i ? (SUPPORT_224 && mode_224_i) : mode_q;
    w_use_iv   = first_i || !chain_q;
    w_h_init   = w_use_iv ? (w_mode_sel ? IV_224 : IV_256) : h_q;
    w_blk_win  = '0;
    for (int i = 0; i < 16; i++) begin
      w_blk_win[i] = block_in_i[511 - 32*i -: 32];
    end
    for (int i = 0; i < 8; i++) begin
      w_h_sum[i] = h_q[i] + work_q[i];
    end
  end

  // ROUNDS_PER_CYCLE chained rounds, sliding the 16-word schedule window once per round.
  always_comb begin : comb_rounds
    hash_t      s;
    win_t       w;
    logic [31:0] t1, t2, nw;
    logic [5:0]  idx;
    s   = work_q;
    w   = w_q;
    t1  = '0;
    t2  = '0;
    nw  = '0;
    idx = '0;
    for (int r = 0; r < ROUNDS_PER_CYCLE; r++) begin
      idx  = rnd_q + 6'(r);
      t1   = s[7] + big_s1(s[4]) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + K_TAB[idx] + w[0];
      t2   = big_s0(s[0]) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      nw   = sml_s1(w[14]) + w[9] + sml_s0(w[1]) + w[0];
      s[7] = s[6];
      s[6] = s[5];
      s[5] = s[4];
      s[4] = s[3] + t1;
      s[3] = s[2];
      s[2] = s[1];
      s[1] = s[0];
      s[0] = t1 + t2;
      w    = {nw, w[15:1]};
    end
    work_d = s;
    win_d  = w;
  end

  // Control FSM with registered handshake/status outputs and the datapath registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      h_q      <= '0;
      work_q   <= '0;
      w_q      <= '0;
      rnd_q    <= '0;
      last_q   <= 1'b0;
      mode_q   <= 1'b0;
      chain_q  <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      dv_q     <= 1'b0;
      digest_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          dv_q <= 1'b0;
          if (w_accept) begin
            w_q     <= w_blk_win;
            h_q     <= w_h_init;
            work_q  <= w_h_init;
            last_q  <= last_i;
            mode_q  <= w_mode_sel;
            rnd_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ROUND;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ROUND: begin
          work_q <= work_d;
          w_q    <= win_d;
          rnd_q  <= rnd_q + RND_STEP;
          if (rnd_q == RND_LAST) begin
            state_q <= FINAL;
          end
        end
        FINAL: begin
          h_q     <= w_h_sum;
          chain_q <= 1'b1;
          busy_q  <= 1'b0;
          if (last_q) begin
            digest_q <= fmt_digest(w_h_sum, mode_q);
            dv_q     <= 1'b1;
            state_q  <= DONE;
          end else begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        DONE: begin
          dv_q    <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_iter_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha256_iter_core
// Description : Self-checking bench for sha256_iter_core, one instance per
//               ROUNDS_PER_CYCLE value (1, 2, 4, 8), compared against known
//               digests and a textbook SHA-256 model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_iter_core;

  localparam logic [255:0] ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO256 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] ABC224 = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;

  localparam logic [31:0] IV256 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] IV224 [8] = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         bv [4];
  logic [511:0] bin [4];
  logic         fi [4];
  logic         la [4];
  logic         md [4];
  logic         rdy [4];
  logic         bsy [4];
  logic         dv [4];
  logic [255:0] dig [4];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [511:0]  blkq [$];
  byte unsigned  msgq [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      sha256_iter_core #(
        .ROUNDS_PER_CYCLE(1 << g),
        .SUPPORT_224     (1'b1)
      ) u_dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .block_valid_i (bv[g]),
        .block_ready_o (rdy[g]),
        .block_in_i    (bin[g]),
        .first_i       (fi[g]),
        .last_i        (la[g]),
        .mode_224_i    (md[g]),
        .busy_o        (bsy[g]),
        .digest_valid_o(dv[g]),
        .digest_o      (dig[g])
      );
    end
  endgenerate

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] ref_hash(input logic m224);
    logic [31:0] H [8];
    logic [31:0] W [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    for (int i = 0; i < 8; i++) H[i] = m224 ? IV224[i] : IV256[i];
    for (int b = 0; b < blkq.size(); b++) begin
      for (int t = 0; t < 16; t++) W[t] = blkq[b][511 - 32*t -: 32];
      for (int t = 16; t < 64; t++)
        W[t] = (rotr(W[t-2], 17) ^ rotr(W[t-2], 19) ^ (W[t-2] >> 10)) + W[t-7]
             + (rotr(W[t-15], 7) ^ rotr(W[t-15], 18) ^ (W[t-15] >> 3)) + W[t-16];
      for (int i = 0; i < 8; i++) v[i] = H[i];
      for (int t = 0; t < 64; t++) begin
        t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
           + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + W[t];
        t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
        v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
        v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) H[i] = H[i] + v[i];
    end
    if (m224) H[7] = 32'h0;
    return {H[0], H[1], H[2], H[3], H[4], H[5], H[6], H[7]};
  endfunction

  task automatic set_str(input string s);
    msgq.delete();
    for (int i = 0; i < s.len(); i++) msgq.push_back(s[i]);
  endtask

  task automatic pad_msg();
    byte unsigned p [$];
    logic [63:0]  bl;
    logic [511:0] blk;
    p = msgq;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(msgq.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    blkq.delete();
    for (int b = 0; b < p.size() / 64; b++) begin
      blk = '0;
      for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = p[64*b + j];
      blkq.push_back(blk);
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input int k, input logic [511:0] b, input logic f, input logic l,
                      input logic m, input string tag, output int acc);
    int g;
    g = 0;
    bv[k] = 1'b1; bin[k] = b; fi[k] = f; la[k] = l; md[k] = m;
    while (!rdy[k] && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) chk({tag, "_accept_timeout"}, 256'(rdy[k]), 256'd1);
    acc = cyc;
    @(negedge clk);
    bv[k] = 1'b0;
  endtask

  task automatic wait_dv(input int k, input int acc, input logic [255:0] exp, input string tag);
    int g;
    g = 0;
    while (!dv[k] && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk({tag, "_latency"}, 256'(cyc - acc), 256'((64 >> k) + 2));
    chk({tag, "_digest"}, dig[k], exp);
    @(negedge clk);
    chk({tag, "_pulse"}, 256'(dv[k]), 256'd0);
  endtask

  // Sends every block in blkq as one message and checks timing and digest.
  task automatic run_msg(input int k, input logic m, input logic [255:0] exp, input string tag);
    int acc, g;
    for (int i = 0; i < blkq.size(); i++) begin
      push(k, blkq[i], (i == 0), (i == blkq.size() - 1), m, tag, acc);
      chk({tag, "_busy"}, 256'({bsy[k], rdy[k]}), 256'(2'b10));
      if (i != blkq.size() - 1) begin
        g = 0;
        while (!rdy[k] && g < 300) begin
          @(negedge clk);
          g++;
        end
        chk({tag, "_ready_gap"}, 256'(cyc - acc - 1), 256'((64 >> k) + 1));
      end else begin
        wait_dv(k, acc, exp, tag);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          acc, acc2, g, n, len;
    logic        m, seen;
    logic [511:0] abc_blk;
    string       t;

    for (int k = 0; k < 4; k++) begin
      bv[k] = 1'b0; bin[k] = '0; fi[k] = 1'b0; la[k] = 1'b0; md[k] = 1'b0;
    end

    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      t = $sformatf("r%0d_rst", 1 << k);
      chk({t, "_ready"}, 256'(rdy[k]), 256'd0);
      chk({t, "_status"}, 256'({bsy[k], dv[k]}), 256'd0);
      chk({t, "_digest"}, dig[k], 256'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++)
      chk($sformatf("r%0d_ready_after_rst", 1 << k), 256'(rdy[k]), 256'd1);

    set_str("abc");
    pad_msg();
    abc_blk = blkq[0];

    for (int k = 0; k < 4; k++) begin
      n = 64 >> k;

      set_str("abc"); pad_msg();
      run_msg(k, 1'b0, ABC256, $sformatf("r%0d_abc256", 1 << k));

      set_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"); pad_msg();
      run_msg(k, 1'b0, TWO256, $sformatf("r%0d_two_blk", 1 << k));

      set_str("abc"); pad_msg();
      run_msg(k, 1'b1, ABC224, $sformatf("r%0d_abc224", 1 << k));

      // Hold a second block on the input while the first is being compressed.
      t = $sformatf("r%0d_hold", 1 << k);
      push(k, abc_blk, 1'b1, 1'b1, 1'b0, t, acc);
      bv[k] = 1'b1; bin[k] = abc_blk; fi[k] = 1'b1; la[k] = 1'b1; md[k] = 1'b1;
      g = 0; seen = 1'b0;
      while (!rdy[k] && g < 300) begin
        if (cyc == acc + 2) chk({t, "_prev_digest"}, dig[k], ABC224);
        if (dv[k]) begin
          seen = 1'b1;
          chk({t, "_first_digest"}, dig[k], ABC256);
        end
        @(negedge clk);
        g++;
      end
      chk({t, "_first_done"}, 256'(seen), 256'd1);
      acc2 = cyc;
      chk({t, "_accept_cycle"}, 256'(acc2 - acc), 256'(n + 3));
      @(negedge clk);
      bv[k] = 1'b0;
      wait_dv(k, acc2, ABC224, {t, "_second"});

      // Randomized messages checked against the model.
      for (int r = 0; r < 3; r++) begin
        len = $urandom_range(0, 130);
        m   = 1'($urandom_range(0, 1));
        msgq.delete();
        for (int i = 0; i < len; i++) msgq.push_back(8'($urandom_range(0, 255)));
        pad_msg();
        run_msg(k, m, ref_hash(m), $sformatf("r%0d_rand%0d_len%0d_m%0d", 1 << k, r, len, m));
      end

      // Reset during round 30 abandons the block.
      t = $sformatf("r%0d_midrst", 1 << k);
      push(k, abc_blk, 1'b1, 1'b1, 1'b0, t, acc);
      g = 0;
      while (cyc < acc + 1 + 30 / (1 << k) && g < 300) begin
        @(negedge clk);
        g++;
      end
      reset_n = 1'b0;
      #1;
      chk({t, "_busy"}, 256'(bsy[k]), 256'd0);
      chk({t, "_digest"}, dig[k], 256'd0);
      chk({t, "_ready"}, 256'(rdy[k]), 256'd0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < n + 4; i++) begin
        @(negedge clk);
        if (dv[k]) chk({t, "_no_dv"}, 256'(dv[k]), 256'd0);
      end
      chk({t, "_digest_stays0"}, dig[k], 256'd0);
      chk({t, "_ready_back"}, 256'(rdy[k]), 256'd1);

      // Non-first block with no chained state starts from the SHA-256 IV.
      push(k, abc_blk, 1'b0, 1'b1, 1'b0, {t, "_nofirst"}, acc);
      wait_dv(k, acc, ABC256, {t, "_nofirst"});

      set_str("abc"); pad_msg();
      run_msg(k, 1'b0, ABC256, {t, "_clean"});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sha256_iter_core.md
SHA256_ITER_CORE -- requirements
Module: sha256_iter_core

Interface
REQ-001 Parameter ROUNDS_PER_CYCLE, default 1, compression rounds per clock; SHALL be one of 1, 2, 4, 8.
REQ-002 Parameter SUPPORT_224, default 1; when 1 the core SHALL support the SHA-224 mode, and when 0 mode_224 SHALL be ignored.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 block_valid  input  1  block_in, first and mode_224 are valid this cycle.
REQ-006 block_ready  output  1  the core can accept a block.
REQ-007 block_in  input  512  padded message block; word 0 is block_in[511:480], big-endian.
REQ-008 first  input  1  the block starts a new message (initial hash from IV, not chained).
REQ-009 last  input  1  the block ends the message.
REQ-010 mode_224  input  1  1 = SHA-224 IV and truncated output; sampled only on a first block.
REQ-011 busy  output  1  compression in progress.
REQ-012 digest_valid  output  1  one-cycle pulse: digest is newly valid.
REQ-013 digest  output  256  final hash H0..H7, with H0 in [255:224].

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, ROUND, FINAL, DONE.
REQ-015 block_ready SHALL be 1 only in IDLE; a block SHALL be accepted only when block_valid && block_ready in the same cycle.
REQ-016 Accepting a block in IDLE SHALL do all of the following, then go to ROUND:
- latch W[0..15] from block_in;
- if first=1, load H from the IV (SHA-256, or SHA-224 when mode_224=1), otherwise keep the chained H;
- copy H into working registers a..h;
- latch last and mode_224 (mode_224 only when first=1);
- clear the round counter.
REQ-017 In ROUND the core SHALL perform ROUNDS_PER_CYCLE rounds per cycle:
- message schedule is a 16-word sliding window, W[t] computed on the fly for t>=16;
- all additions are modulo 2^32.
REQ-018 The round counter SHALL be 6 bits; after round 63 completes the FSM SHALL go to FINAL, so ROUND lasts exactly 64/ROUNDS_PER_CYCLE cycles.
REQ-019 In FINAL the core SHALL set H[i] = H[i] + working[i] mod 2^32; then:
- if last=1, go to DONE;
- if last=0, go to IDLE with H retained for chaining.
REQ-020 In DONE the core SHALL assert digest_valid for exactly one cycle and drive digest from H, then return to IDLE.
REQ-021 In SHA-224 mode digest[31:0] SHALL be forced to 0.
REQ-022 digest SHALL hold its value until the next DONE; it SHALL NOT change during a later message's rounds.
REQ-023 Latency: acceptance to digest_valid SHALL be 64/ROUNDS_PER_CYCLE + 2 cycles for a last block.
REQ-024 Non-last block back-to-back throughput: the next block SHALL be acceptable 64/ROUNDS_PER_CYCLE + 1 cycles after acceptance.
REQ-025 busy SHALL be 1 in ROUND and FINAL, and 0 otherwise.
REQ-026 block_valid while not ready SHALL be ignored, with no state change; the source holds the block until accepted.
REQ-027 A non-first block received with no chained state since reset SHALL be processed from the IV and SHALL NOT hang.
REQ-028 first=1 and last=1 together SHALL be legal, giving a single-block message.

Reset
REQ-029 Asserting reset_n=0 SHALL asynchronously force:
- state=IDLE;
- block_ready=0 while reset is held;
- busy=0, digest_valid=0, digest=0;
- H=0, round counter=0;
- stored mode=SHA-256.
REQ-030 After reset deassertion, block_ready SHALL be 1 from the first rising edge onward.
REQ-031 Reset mid-operation SHALL abandon the block: no digest_valid, and digest stays 0.

Verification
REQ-032 Single block "abc" padded (616263 80 00.. len 0x18), first=last=1, SHA-256 -> digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad after 66 cycles (R=1).
REQ-033 448-bit "abcdbcde...nopq" sent as two blocks (first, then last) -> digest 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1; block 2 accepted exactly 65 cycles after block 1.
REQ-034 Single block "abc", mode_224=1 -> digest 23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7_00000000.
REQ-035 block_valid held high during ROUND -> block_ready=0 and no acceptance; the held block is accepted on the first IDLE cycle; the in-flight digest is unchanged.
REQ-036 reset_n pulsed low at round 30 -> busy=0 and digest=0 immediately; then "abc" -> the correct digest, identical to a clean run.
REQ-037 Repeat REQ-032 and REQ-033 for ROUNDS_PER_CYCLE = 2, 4 and 8 -> same digests, with latencies 34, 18 and 10 cycles.
